// File: rtl/fetch_if_stage_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and decode handshakes.
// master = the fetch stage, slave = its surroundings (imem, execute, decode).
interface fetch_if_stage_if #(
  parameter int XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic [1:0]      id_imm_src;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_imm_src,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_imm_src,
    output id_ready
  );
endinterface

// File: rtl/fetch_if_stage.sv
// RV64 instruction-fetch stage: owns the PC, issues one word fetch at a time and
// buffers returned words for decode. Define FETCH_PERF_CNT_EN to add stall/drop counters.
//
// state | meaning
// FETCH | no request outstanding; request when a buffer slot is free
// WAIT  | one request outstanding; its response will be buffered
// DROP  | one request outstanding; its response is stale and will be discarded
module fetch_if_stage #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_if_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_drop_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             run_q;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  issued_pc_q;
  logic [31:0]      buf_instr [FIFO_DEPTH];
  logic [XLEN-1:0]  buf_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             req, issue, push, pop, id_valid, head_load;
  logic [31:0]      head_instr_d;
  logic [XLEN-1:0]  head_pc_d;
  logic [31:0]      id_instr_q;
  logic [XLEN-1:0]  id_pc_q;
  logic [1:0]       id_imm_src_q;

  function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  assign id_valid = (count_q != '0);
  assign pop      = id_valid && bus.id_ready && !bus.redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = 1'b0;
    issue   = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // A slot is free here, and it stays reserved until the response returns.
        req = run_q && (count_q < CNT_W'(FIFO_DEPTH));
        if (req && bus.imem_gnt) begin
          issue   = 1'b1;
          state_d = S_WAIT;
          pc_d    = pc_q + XLEN'(4);
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          push    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (bus.imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~XLEN'(3);
      push = 1'b0;
      // Anything still in flight after this edge belongs to the old path.
      if (issue || (state_q != S_FETCH && !bus.imem_rvalid)) state_d = S_DROP;
      else                                                   state_d = S_FETCH;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    head_load = (count_d != '0);
    // A push into an otherwise-empty buffer becomes the new head directly.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_instr_d = bus.imem_rdata;
      head_pc_d    = issued_pc_q;
    end else begin
      head_instr_d = buf_instr[rd_ptr_d];
      head_pc_d    = buf_pc[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      run_q        <= 1'b0;
      pc_q         <= RESET_PC;
      issued_pc_q  <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      id_imm_src_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (issue) issued_pc_q <= pc_q;
      if (bus.redirect_valid) wr_ptr_q <= '0;
      else if (push)          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (head_load) begin
        id_instr_q   <= head_instr_d;
        id_pc_q      <= head_pc_d;
        id_imm_src_q <= imm_src_of(head_instr_d[6:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= bus.imem_rdata;
      buf_pc[wr_ptr_q]    <= issued_pc_q;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.id_valid   = id_valid;
  assign bus.id_instr   = id_instr_q;
  assign bus.id_pc      = id_pc_q;
  assign bus.id_imm_src = id_imm_src_q;

`ifdef FETCH_PERF_CNT_EN
  logic drop;
  assign drop = bus.imem_rvalid &&
                ((state_q == S_DROP) || (state_q == S_WAIT && bus.redirect_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (bus.id_ready && !id_valid && !bus.redirect_valid && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (drop && (perf_drop_cnt != '1))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_if_stage.sv
// Bench for fetch_if_stage: directed scenarios plus a randomized run against an
// in-order PC-stream model; imem is modelled as a single-outstanding responder.
module tb_fetch_if_stage;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if_stage_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_drop_cnt;
`endif

  fetch_if_stage #(.XLEN(XLEN), .RESET_PC(64'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit          mem_auto;
  int          gnt_pct, lat_min, lat_max;
  bit          out_busy;
  logic [63:0] out_addr;
  int          out_delay;
  bit          stale_en;
  logic [31:0] stale_word;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [24:0] hi;
    hi = a[31:7] ^ a[56:32];
    case (a[4:2])
      3'd0:    return 32'h00112623;
      3'd1:    return 32'hFE000EE3;
      3'd2:    return 32'h0100006F;
      3'd3:    return 32'h00A00093;
      3'd4:    return {hi, 7'b0000011};
      3'd5:    return {hi, 7'b0110111};
      3'd6:    return {hi, 7'b1100111};
      default: return {hi, 7'b0110011};
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [31:0] w);
    if (w[6:0] == 7'b0100011) return 2'b01;
    if (w[6:0] == 7'b1100011) return 2'b10;
    if (w[6:0] == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // One clock: advance across the edge, then let the imem model react.
  task automatic cycle();
    bit granted, responded;
    logic [63:0] a;
    granted   = bus.imem_req && bus.imem_gnt;
    responded = bus.imem_rvalid;
    a         = bus.imem_addr;
    @(posedge clk);
    #1;
    if (!mem_auto) return;
    if (responded) begin
      out_busy = 1'b0;
      stale_en = 1'b0;
    end
    if (granted) begin
      out_busy  = 1'b1;
      out_addr  = a;
      out_delay = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    bus.imem_rvalid = 1'b0;
    if (out_busy) begin
      if (out_delay == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = stale_en ? stale_word : mem_word(out_addr);
      end else begin
        out_delay--;
      end
    end
    bus.imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    mem_auto = 1'b1; gnt_pct = 100; lat_min = 1; lat_max = 1;
    out_busy = 1'b0; stale_en = 1'b0; stale_word = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.imem_gnt = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.imem_addr); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.id_valid); end
    checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", bus.id_instr); end
    checks++; if (bus.id_pc !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", bus.id_pc); end
    checks++; if (bus.id_imm_src !== 2'b00) begin errors++; $display("FAIL rst_imm: got %b expected 00", bus.id_imm_src); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [4];
    logic [1:0]  exp_s [4];
    int first_gnt, first_valid, ngnt, npop;
    exp_w = '{32'h00112623, 32'hFE000EE3, 32'h0100006F, 32'h00A00093};
    exp_s = '{2'b01, 2'b10, 2'b11, 2'b00};
    apply_reset();
    bus.id_ready = 1'b1;
    first_gnt = -1; first_valid = -1; ngnt = 0; npop = 0;
    for (int obs = 0; obs < 60 && npop < 4; obs++) begin
      if (bus.imem_req && bus.imem_gnt) begin
        if (first_gnt < 0) first_gnt = obs;
        if (ngnt < 3) begin
          checks++;
          if (bus.imem_addr !== 64'(ngnt * 4)) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", ngnt, bus.imem_addr, 64'(ngnt * 4)); end
        end
        ngnt++;
      end
      if (bus.id_valid && first_valid < 0) first_valid = obs;
      if (bus.id_valid && bus.id_ready) begin
        checks++; if (bus.id_pc !== 64'(npop * 4)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", npop, bus.id_pc, 64'(npop * 4)); end
        checks++; if (bus.id_instr !== exp_w[npop]) begin errors++; $display("FAIL seq_instr%0d: got %h expected %h", npop, bus.id_instr, exp_w[npop]); end
        checks++; if (bus.id_imm_src !== exp_s[npop]) begin errors++; $display("FAIL seq_imm%0d: got %b expected %b", npop, bus.id_imm_src, exp_s[npop]); end
        npop++;
      end
      cycle();
    end
    checks++; if (first_gnt < 0 || first_valid - first_gnt != 2) begin errors++; $display("FAIL seq_latency: got %0d expected 2", first_valid - first_gnt); end
    checks++; if (npop != 4) begin errors++; $display("FAIL seq_timeout: got %0d pops expected 4", npop); end
  endtask

  task automatic test_backpressure();
    int ngnt, npop;
    apply_reset();
    ngnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req && bus.imem_gnt) ngnt++;
      cycle();
    end
    checks++; if (ngnt != DEPTH) begin errors++; $display("FAIL bp_grants: got %0d expected %0d", ngnt, DEPTH); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", bus.id_valid); end
    bus.id_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 40 && npop < 3; i++) begin
      if (bus.id_valid && bus.id_ready) begin
        checks++; if (bus.id_pc !== 64'(npop * 4)) begin errors++; $display("FAIL bp_pc%0d: got %h expected %h", npop, bus.id_pc, 64'(npop * 4)); end
        checks++; if (bus.id_instr !== mem_word(64'(npop * 4))) begin errors++; $display("FAIL bp_instr%0d: got %h expected %h", npop, bus.id_instr, mem_word(64'(npop * 4))); end
        npop++;
      end
      cycle();
    end
    checks++; if (npop != 3) begin errors++; $display("FAIL bp_timeout: got %0d pops expected 3", npop); end
  endtask

  task automatic test_redirect_wait();
    bit got, seen_gnt, seen_pop;
    apply_reset();
    bus.id_ready = 1'b1;
    lat_min = 2; lat_max = 2;
    stale_en = 1'b1; stale_word = 32'hDEADBEEF;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      got = bus.imem_req && bus.imem_gnt;
      cycle();
    end
    checks++; if (!got) begin errors++; $display("FAIL rw_grant: got none expected a grant"); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h1003;
    cycle();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.imem_addr !== 64'h1000) begin errors++; $display("FAIL rw_addr: got %h expected 1000", bus.imem_addr); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b expected 0", bus.id_valid); end
    seen_gnt = 1'b0; seen_pop = 1'b0;
    for (int i = 0; i < 40 && !seen_pop; i++) begin
      if (bus.imem_req && bus.imem_gnt && !seen_gnt) begin
        seen_gnt = 1'b1;
        checks++; if (bus.imem_addr !== 64'h1000) begin errors++; $display("FAIL rw_gnt_addr: got %h expected 1000", bus.imem_addr); end
      end
      if (bus.id_valid && bus.id_ready) begin
        seen_pop = 1'b1;
        checks++; if (bus.id_pc !== 64'h1000) begin errors++; $display("FAIL rw_pc: got %h expected 1000", bus.id_pc); end
        checks++; if (bus.id_instr !== mem_word(64'h1000)) begin errors++; $display("FAIL rw_instr: got %h expected %h", bus.id_instr, mem_word(64'h1000)); end
      end
      cycle();
    end
    checks++; if (!seen_pop) begin errors++; $display("FAIL rw_timeout: got no pop expected one"); end
  endtask

  task automatic test_redirect_pop_full();
    logic [63:0] tgt;
    bit seen_pop;
    apply_reset();
    repeat (10) cycle();
    checks++; if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b1) begin errors++; $display("FAIL rf_full: got req=%b valid=%b expected req=0 valid=1", bus.imem_req, bus.id_valid); end
    tgt = {$urandom, $urandom};
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = tgt;
    cycle();
    bus.redirect_valid = 1'b0;
    tgt = {tgt[63:2], 2'b00};
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b expected 0", bus.id_valid); end
    checks++; if (bus.imem_addr !== tgt) begin errors++; $display("FAIL rf_addr: got %h expected %h", bus.imem_addr, tgt); end
    seen_pop = 1'b0;
    for (int i = 0; i < 40 && !seen_pop; i++) begin
      if (bus.id_valid && bus.id_ready) begin
        seen_pop = 1'b1;
        checks++; if (bus.id_pc !== tgt) begin errors++; $display("FAIL rf_pc: got %h expected %h", bus.id_pc, tgt); end
        checks++; if (bus.id_instr !== mem_word(tgt)) begin errors++; $display("FAIL rf_instr: got %h expected %h", bus.id_instr, mem_word(tgt)); end
      end
      cycle();
    end
    checks++; if (!seen_pop) begin errors++; $display("FAIL rf_timeout: got no pop expected one"); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc;
    int npop;
    apply_reset();
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFA;
    cycle();
    bus.redirect_valid = 1'b0;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    npop = 0;
    for (int i = 0; i < 60 && npop < 3; i++) begin
      if (bus.id_valid && bus.id_ready) begin
        checks++; if (bus.id_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc%0d: got %h expected %h", npop, bus.id_pc, exp_pc); end
        exp_pc = exp_pc + 64'd4;
        npop++;
      end
      cycle();
    end
    checks++; if (npop != 3) begin errors++; $display("FAIL wrap_timeout: got %0d pops expected 3", npop); end
  endtask

  task automatic test_reset_mid();
    bit got, seen_pop;
    apply_reset();
    bus.id_ready = 1'b1;
    lat_min = 3; lat_max = 3;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      got = bus.imem_req && bus.imem_gnt;
      cycle();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 64'h0) begin errors++; $display("FAIL rm_async: got req=%b addr=%h expected req=0 addr=0", bus.imem_req, bus.imem_addr); end
    mem_auto = 1'b0; out_busy = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    cycle();
    bus.imem_rvalid = 1'b0;
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rm_late: got %b expected 0", bus.id_valid); end
    mem_auto = 1'b1; lat_min = 1; lat_max = 1; bus.imem_gnt = 1'b1;
    seen_pop = 1'b0;
    for (int i = 0; i < 40 && !seen_pop; i++) begin
      if (bus.id_valid && bus.id_ready) begin
        seen_pop = 1'b1;
        checks++; if (bus.id_pc !== 64'h0 || bus.id_instr !== 32'h00112623) begin errors++; $display("FAIL rm_first: got pc=%h instr=%h expected pc=0 instr=00112623", bus.id_pc, bus.id_instr); end
      end
      cycle();
    end
    checks++; if (!seen_pop) begin errors++; $display("FAIL rm_timeout: got no pop expected one"); end
  endtask

  task automatic test_random();
    logic [63:0] exp_pc, tgt;
    bit redir, after_redir;
    int npop;
    apply_reset();
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    exp_pc = 64'h0; npop = 0; after_redir = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (after_redir) begin
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush@%0d: got %b expected 0", cyc, bus.id_valid); end
      end
      if (bus.imem_addr[1:0] !== 2'b00) begin
        checks++; errors++; $display("FAIL rnd_align@%0d: got %h expected low bits 00", cyc, bus.imem_addr);
      end
      bus.id_ready = ($urandom_range(3, 0) != 0);
      redir = ($urandom_range(49, 0) == 0);
      tgt = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) tgt[63:6] = '1;
      bus.redirect_valid = redir;
      bus.redirect_pc = tgt;
      if (!redir && bus.id_valid && bus.id_ready) begin
        checks++; if (bus.id_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h expected %h", cyc, bus.id_pc, exp_pc); end
        checks++; if (bus.id_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_instr@%0d: got %h expected %h", cyc, bus.id_instr, mem_word(exp_pc)); end
        checks++; if (bus.id_imm_src !== exp_imm(mem_word(exp_pc))) begin errors++; $display("FAIL rnd_imm@%0d: got %b expected %b", cyc, bus.id_imm_src, exp_imm(mem_word(exp_pc))); end
        exp_pc = exp_pc + 64'd4;
        npop++;
      end
      cycle();
      if (redir) exp_pc = {tgt[63:2], 2'b00};
      after_redir = redir;
    end
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    checks++; if (npop < 200) begin errors++; $display("FAIL rnd_progress: got %0d pops expected at least 200", npop); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    bit got;
    apply_reset();
    gnt_pct = 0; bus.imem_gnt = 1'b0;
    bus.id_ready = 1'b1;
    repeat (3) cycle();
    bus.id_ready = 1'b0;
    gnt_pct = 100; bus.imem_gnt = 1'b1; lat_min = 2; lat_max = 2;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      got = bus.imem_req && bus.imem_gnt;
      cycle();
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h200;
    cycle();
    bus.redirect_valid = 1'b0;
    repeat (6) cycle();
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("FAIL perf_stall: got %0d expected 3", perf_stall_cnt); end
    checks++; if (perf_drop_cnt !== 32'd1) begin errors++; $display("FAIL perf_drop: got %0d expected 1", perf_drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_pop_full();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
